// File: rtl/wb_arb_pkg.sv
// Shared types and limits for the Wishbone RAM arbiter and its round-robin picker.
package wb_arb_pkg;
  localparam int MAX_MASTERS = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } wb_arb_state_e;
endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr_i, wrapping modulo NUM_MASTERS.
module wb_arb_rr_pick #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       rr_ptr_i,
  output logic                   valid_o,
  output logic [IDX_W-1:0]       idx_o
);

  logic [IDX_W:0] sum;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    sum     = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_MASTERS)) begin
        sum = sum - (IDX_W+1)'(NUM_MASTERS);
      end
      if (req_i[sum[IDX_W-1:0]]) begin
        idx_o = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone classic arbiter sharing one wb_ram slave; grant held for the owner's whole cyc.
// Define WB_ARB_TIMEOUT_EN to build the stalled-strobe timeout that pulses m_err_o.
module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  output logic                              s_we_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  input  logic                              s_ack_i,
  input  logic [DATA_WIDTH-1:0]             s_dat_i
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_num_masters
    $error("wb_ram_arbiter: NUM_MASTERS must be 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("wb_ram_arbiter: TIMEOUT must be at least 1");
  end

  wb_arb_state_e    state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;

  logic [ADDR_WIDTH-1:0] adr_a [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] dat_a [NUM_MASTERS];
  logic [SEL_WIDTH-1:0]  sel_a [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_split
    assign adr_a[k] = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_a[k] = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign sel_a[k] = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
  end

  wb_arb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req_i    (m_cyc_i & m_stb_i),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_vld),
    .idx_o    (pick_idx)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          grant_d = pick_idx;
        end
      end
      GRANT: begin
        if (!m_cyc_i[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // IDLE drives nothing and swallows any late slave ack.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    if (state_q == GRANT) begin
      s_adr_o          = adr_a[grant_q];
      s_dat_o          = dat_a[grant_q];
      s_sel_o          = sel_a[grant_q];
      s_we_o           = m_we_i[grant_q];
      s_cyc_o          = m_cyc_i[grant_q];
      s_stb_o          = m_stb_i[grant_q];
      m_ack_o[grant_q] = s_ack_i;
    end
  end

  assign m_dat_o = {NUM_MASTERS{s_dat_i}};

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stalled;
  logic             to_hit;

  assign stalled = (state_q == GRANT) && s_stb_o && !s_ack_i;
  assign to_hit  = stalled && (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    cnt_d = '0;
    if (stalled && !to_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    m_err_o = '0;
    if (to_hit) begin
      m_err_o[grant_q] = 1'b1;
    end
  end
`else
  assign m_err_o = '0;
`endif

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter with two masters and a registered-ack RAM model.
module tb_wb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] m_adr, m_dat, m_dat_o;
  logic [7:0]  m_sel;
  logic [1:0]  m_we, m_cyc, m_stb, m_ack, m_err;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, s_ack;

  logic [31:0] mem [16];
  logic        ram_ack = 1'b0;
  logic [31:0] ram_dat = 32'h0;
  logic        stall   = 1'b0;
  logic        inj_ack = 1'b0;
  logic [1:0]  exp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_ram_arbiter #(
    .NUM_MASTERS (2),
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .SEL_WIDTH   (4),
    .TIMEOUT     (4)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat),
    .m_sel_i  (m_sel),
    .m_we_i   (m_we),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_ack_o  (m_ack),
    .m_err_o  (m_err),
    .m_dat_o  (m_dat_o),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel),
    .s_we_o   (s_we),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_ack_i  (s_ack),
    .s_dat_i  (s_dat_i)
  );

  // RAM acks one cycle after strobe; it has no reset so it can ack into a reset.
  assign s_ack   = ram_ack | inj_ack;
  assign s_dat_i = ram_dat;

  always @(posedge clk) begin
    if (s_cyc && s_stb && !ram_ack && !stall) begin
      ram_ack <= 1'b1;
      ram_dat <= mem[s_adr[5:2]];
      if (s_we) mem[s_adr[5:2]] <= s_dat_o;
    end else begin
      ram_ack <= 1'b0;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[k]         = cyc;
    m_stb[k]         = stb;
    m_we[k]          = we;
    m_adr[k*32 +: 32] = adr;
    m_dat[k*32 +: 32] = dat;
  endtask

  initial begin
    rst   = 1'b1;
    m_adr = '0;
    m_dat = '0;
    m_sel = 8'hFF;
    m_we  = '0;
    m_cyc = '0;
    m_stb = '0;
    tick();
    tick();
    check_val("rst_s_cyc", s_cyc, 0);
    check_val("rst_s_stb", s_stb, 0);
    check_val("rst_s_we", s_we, 0);
    check_val("rst_s_adr", s_adr, 0);
    check_val("rst_s_dat", s_dat_o, 0);
    check_val("rst_s_sel", s_sel, 0);
    check_val("rst_m_ack", m_ack, 0);
    check_val("rst_m_err", m_err, 0);
    rst = 1'b0;

    // single write then read-back by master 1
    drive(1, 1, 1, 1, 32'h10, 32'hDEADBEEF);
    #1;
    check_val("wr_arb_cycle", s_stb, 0);
    tick();
    check_val("wr_s_stb", s_stb, 1);
    check_val("wr_s_adr", s_adr, 32'h10);
    check_val("wr_s_dat", s_dat_o, 32'hDEADBEEF);
    check_val("wr_s_we", s_we, 1);
    check_val("wr_s_sel", s_sel, 4'hF);
    check_val("wr_ack_early", m_ack, 2'b00);
    tick();
    check_val("wr_ack", m_ack, 2'b10);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    check_val("wr_release", m_ack, 2'b00);
    drive(1, 1, 1, 0, 32'h10, 0);
    tick();
    check_val("rd_s_we", s_we, 0);
    check_val("rd_s_stb", s_stb, 1);
    tick();
    check_val("rd_ack", m_ack, 2'b10);
    check_val("rd_dat_m1", m_dat_o[63:32], 32'hDEADBEEF);
    check_val("rd_dat_copy", m_dat_o[31:0], 32'hDEADBEEF);
    drive(1, 0, 0, 0, 0, 0);
    tick();

    // tie after reset: master 0 first, master 1 after the handover idle cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1, 1, 0, 32'h20, 0);
    drive(1, 1, 1, 0, 32'h30, 0);
    tick();
    check_val("tie1_owner", s_adr, 32'h20);
    tick();
    check_val("tie1_ack0", m_ack, 2'b01);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check_val("tie1_handover_stb", s_stb, 0);
    check_val("tie1_handover_ack", m_ack, 2'b00);
    tick();
    check_val("tie1_second", s_adr, 32'h30);
    tick();
    check_val("tie1_ack1", m_ack, 2'b10);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 1, 0, 32'h20, 0);
    drive(1, 1, 1, 0, 32'h30, 0);
    tick();
    check_val("tie2_owner", s_adr, 32'h20);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 1, 0, 32'h20, 0);
    drive(1, 1, 1, 0, 32'h30, 0);
    tick();
    check_val("tie3_owner", s_adr, 32'h30);
    tick();
    check_val("tie3_ack", m_ack, 2'b10);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    tick();

    // master 0 holds cyc over three strobes while master 1 waits
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1, 1, 0, 32'h0, 0);
    drive(1, 1, 1, 1, 32'h3C, 32'h55);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 32'(i * 4), 0);
      #1;
      check_val("held_adr", s_adr, 32'(i * 4));
      tick();
      check_val("held_ack", m_ack, 2'b01);
      drive(0, 1, 0, 0, 32'(i * 4), 0);
      tick();
      check_val("held_gap", {m_ack, s_cyc, s_stb, s_we}, 5'b00100);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check_val("held_release", {m_ack, s_cyc}, 3'b000);
    tick();
    check_val("held_next_adr", s_adr, 32'h3C);
    check_val("held_next_we", s_we, 1);
    tick();
    check_val("held_next_ack", m_ack, 2'b10);
    drive(1, 0, 0, 0, 0, 0);
    tick();

    // abandoned strobe: stray ack in the following idle cycle must be dropped
    drive(0, 1, 1, 0, 32'h4, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check_val("abandon_stb", s_stb, 0);
    tick();
    inj_ack = 1'b1;
    #1;
    check_val("abandon_stray", m_ack, 2'b00);
    tick();
    inj_ack = 1'b0;

    // reset while granted, then a normal master 1 grant
    drive(1, 1, 1, 0, 32'h10, 0);
    tick();
    check_val("rstmid_pre", s_stb, 1);
    rst = 1'b1;
    tick();
    check_val("rstmid_s_cyc", s_cyc, 0);
    check_val("rstmid_s_stb", s_stb, 0);
    check_val("rstmid_s_adr", s_adr, 0);
    check_val("rstmid_ack", m_ack, 2'b00);
    rst = 1'b0;
    tick();
    check_val("rstmid_regrant", {s_stb, s_adr}, {1'b1, 32'h10});
    tick();
    check_val("rstmid_ack1", m_ack, 2'b10);
    check_val("rstmid_dat", m_dat_o[63:32], 32'hDEADBEEF);
    drive(1, 0, 0, 0, 0, 0);
    tick();

    // stalled slave: timeout pulse only when the feature is built
    stall = 1'b1;
    drive(0, 1, 1, 0, 32'h8, 0);
    tick();
    for (int i = 1; i <= 6; i++) begin
      tick();
`ifdef WB_ARB_TIMEOUT_EN
      exp_err = (i == 4) ? 2'b01 : 2'b00;
`else
      exp_err = 2'b00;
`endif
      check_val("timeout_err", m_err, exp_err);
    end
    stall = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
